// File: rtl/sram_ctrl_pkg.sv
// Shared types and sizing for the 2048x16 asynchronous SRAM controller.
// Also holds the strobe-length limits used by the controller and its timer.
package sram_ctrl_pkg;

   localparam int unsigned ADDR_W_DEF = 11;
   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned DEPTH      = 2048;
   localparam int unsigned WAIT_MAX   = 15;
   localparam int unsigned TIMER_W    = $clog2(WAIT_MAX + 1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      CLEAR
   } ctrlState_t;

endpackage

// File: rtl/sram_ctrl_timer.sv
// Loadable down-counter that measures the strobe-low interval.
// done is registered and is high whenever the count has reached zero.
module sram_ctrl_timer
   import sram_ctrl_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               load,
   input  logic [TIMER_W-1:0] loadVal,
   output logic               done
);

   logic [TIMER_W-1:0] count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
         done  <= 1'b1;
      end else if (load) begin
         count <= loadVal;
         done  <= (loadVal == '0);
      end else if (count != '0) begin
         count <= count - TIMER_W'(1);
         done  <= (count == TIMER_W'(1));
      end
   end

endmodule

// File: rtl/sram_ctrl.sv
// Single-word read/write sequencer for an asynchronous SRAM (setup, strobe, hold).
// SRAM_CTRL_INIT_CLEAR_EN adds a post-reset sweep that writes zero to every word.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W      = ADDR_W_DEF,
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              init_done,
   output logic [ADDR_W-1:0] sram_addr,
   inout  wire  [DATA_W-1:0] sram_data,
   output logic              sram_weBar,
   output logic              sram_oeBar
);

   if (WAIT_CYCLES == 0 || WAIT_CYCLES > WAIT_MAX) begin : gBadWait
      $error("sram_ctrl: WAIT_CYCLES must be in 1..%0d", WAIT_MAX);
   end

   localparam logic [TIMER_W-1:0] STROBE_LOAD = TIMER_W'(WAIT_CYCLES - 1);

   ctrlState_t        state;
   logic              writeQ;
   logic [DATA_W-1:0] wdataQ;
   logic              driveEn;
   logic              timerDone;

   // Bus enable is a register so the async reset releases the bus immediately.
   assign sram_data = driveEn ? wdataQ : {DATA_W{1'bz}};

   sram_ctrl_timer u_timer (
      .clock   (clock),
      .reset   (reset),
      .load    (state == SETUP),
      .loadVal (STROBE_LOAD),
      .done    (timerDone)
   );

`ifdef SRAM_CTRL_INIT_CLEAR_EN
   logic clearing;
`else
   assign init_done = 1'b1;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
`ifdef SRAM_CTRL_INIT_CLEAR_EN
         state     <= CLEAR;
         req_ready <= 1'b0;
         init_done <= 1'b0;
         clearing  <= 1'b1;
`else
         state     <= IDLE;
         req_ready <= 1'b1;
`endif
         writeQ     <= 1'b0;
         wdataQ     <= '0;
         driveEn    <= 1'b0;
         sram_addr  <= '0;
         sram_weBar <= 1'b1;
         sram_oeBar <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  state     <= SETUP;
                  req_ready <= 1'b0;
                  writeQ    <= req_write;
                  wdataQ    <= req_wdata;
                  sram_addr <= req_addr;
                  driveEn   <= req_write;
               end
            end
            SETUP: begin
               state      <= STROBE;
               sram_weBar <= ~writeQ;
               sram_oeBar <= writeQ;
            end
            STROBE: begin
               if (timerDone) begin
                  state      <= HOLD;
                  sram_weBar <= 1'b1;
                  sram_oeBar <= 1'b1;
`ifdef SRAM_CTRL_INIT_CLEAR_EN
                  rsp_valid  <= ~clearing;
`else
                  rsp_valid  <= 1'b1;
`endif
                  if (!writeQ) begin
                     rsp_rdata <= sram_data;
                  end
               end
            end
            HOLD: begin
               driveEn <= 1'b0;
`ifdef SRAM_CTRL_INIT_CLEAR_EN
               if (!clearing) begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
               end else if (sram_addr == ADDR_W'(DEPTH - 1)) begin
                  state     <= IDLE;
                  clearing  <= 1'b0;
                  init_done <= 1'b1;
                  req_ready <= 1'b1;
               end else begin
                  state     <= CLEAR;
                  sram_addr <= sram_addr + ADDR_W'(1);
               end
`else
               state     <= IDLE;
               req_ready <= 1'b1;
`endif
            end
`ifdef SRAM_CTRL_INIT_CLEAR_EN
            // One cycle per word playing the part of the accept cycle.
            CLEAR: begin
               state   <= SETUP;
               writeQ  <= 1'b1;
               wdataQ  <= '0;
               driveEn <= 1'b1;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: one instance with WAIT_CYCLES=1, one with 4,
// each attached to a behavioural asynchronous SRAM.
`timescale 1ns/1ps
module tb_sram_ctrl;
   import sram_ctrl_pkg::*;

   localparam int unsigned AW = 11;
   localparam int unsigned DW = 16;
   localparam int unsigned W0 = 1;
   localparam int unsigned W1 = 4;
   localparam logic [DW-1:0] PROBE = 16'hA5C3;

   typedef struct {
      logic          wr;
      logic [DW-1:0] data;
      int            acc;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   logic [1:0]         reqValid, reqWrite, reqReady, rspValid, initDone, weBar, oeBar, probeEn;
   logic [1:0][AW-1:0] reqAddr, sramAddr;
   logic [1:0][DW-1:0] reqWdata, rspRdata;
   wire  [DW-1:0]      sramData0, sramData1;

   logic [DW-1:0] mem    [2][DEPTH];
   logic [DW-1:0] shadow [2][DEPTH];
   logic [DW-1:0] lastRead [2];
   int            lowRunOe [2];
   int            lowRunWe [2];
   exp_t          q0[$], q1[$];
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;
   logic          monEn = 1'b0;

   sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W0)) dut0 (
      .clock(clock), .reset(reset),
      .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_write(reqWrite[0]),
      .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]),
      .rsp_valid(rspValid[0]), .rsp_rdata(rspRdata[0]), .init_done(initDone[0]),
      .sram_addr(sramAddr[0]), .sram_data(sramData0),
      .sram_weBar(weBar[0]), .sram_oeBar(oeBar[0])
   );

   sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W1)) dut1 (
      .clock(clock), .reset(reset),
      .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_write(reqWrite[1]),
      .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]),
      .rsp_valid(rspValid[1]), .rsp_rdata(rspRdata[1]), .init_done(initDone[1]),
      .sram_addr(sramAddr[1]), .sram_data(sramData1),
      .sram_weBar(weBar[1]), .sram_oeBar(oeBar[1])
   );

   // SRAM model: drives on oeBar low, writes on a clock edge while weBar is low.
   assign sramData0 = !oeBar[0] ? mem[0][sramAddr[0]] : {DW{1'bz}};
   assign sramData0 = probeEn[0] ? PROBE : {DW{1'bz}};
   assign sramData1 = !oeBar[1] ? mem[1][sramAddr[1]] : {DW{1'bz}};
   assign sramData1 = probeEn[1] ? PROBE : {DW{1'bz}};

   always @(posedge clock) begin
      cyc++;
      if (!weBar[0]) mem[0][sramAddr[0]] = sramData0;
      if (!weBar[1]) mem[1][sramAddr[1]] = sramData1;
   end

   function automatic logic [DW-1:0] busVal(input int i);
      return (i == 0) ? sramData0 : sramData1;
   endfunction

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic handleRsp(input int i, input int unsigned w);
      exp_t e;
      if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
         checkVal("rspUnexpected", 32'(rspValid[i]), 32'(0));
         return;
      end
      if (i == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      checkVal("rspLatency", 32'(cyc - e.acc), 32'(w + 2));
      if (e.wr) begin
         checkVal("rdataHold", 32'(rspRdata[i]), 32'(lastRead[i]));
      end else begin
         checkVal("rdata", 32'(rspRdata[i]), 32'(e.data));
         lastRead[i] = e.data;
      end
   endtask

   always @(negedge clock) begin : monitor
      int unsigned w;
      if (monEn) begin
         for (int i = 0; i < 2; i++) begin
            w = (i == 0) ? W0 : W1;
            checkVal("strobeOverlap", 32'(weBar[i] | oeBar[i]), 32'(1));
            if (!oeBar[i]) begin
               lowRunOe[i]++;
               checkVal("busUnderOe", 32'(busVal(i)), 32'(mem[i][sramAddr[i]]));
            end else if (lowRunOe[i] != 0) begin
               checkVal("oeLowLen", 32'(lowRunOe[i]), 32'(w));
               lowRunOe[i] = 0;
            end
            if (!weBar[i]) begin
               lowRunWe[i]++;
            end else if (lowRunWe[i] != 0) begin
               checkVal("weLowLen", 32'(lowRunWe[i]), 32'(w));
               lowRunWe[i] = 0;
            end
            if (rspValid[i]) handleRsp(i, w);
         end
      end
   end

   // Called at a falling edge; returns at the falling edge after the accept edge.
   task automatic doReq(input int i, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int acc);
      exp_t e;
      int   budget = 0;
      reqValid[i] = 1'b1;
      reqWrite[i] = wr;
      reqAddr[i]  = a;
      reqWdata[i] = d;
      while (!reqReady[i] && budget < 100) begin
         @(negedge clock);
         budget++;
      end
      checkVal("acceptTimeout", 32'(reqReady[i]), 32'(1));
      acc = cyc;
      if (reqReady[i]) begin
         e.wr   = wr;
         e.data = wr ? d : shadow[i][a];
         e.acc  = acc;
         if (wr) shadow[i][a] = d;
         if (i == 0) q0.push_back(e);
         else        q1.push_back(e);
         @(negedge clock);
      end
      reqValid[i] = 1'b0;
   endtask

   task automatic checkResetState(input string tag, input logic expReady);
      for (int i = 0; i < 2; i++) begin
         checkVal({tag, "WeBar"},   32'(weBar[i]),    32'(1));
         checkVal({tag, "OeBar"},   32'(oeBar[i]),    32'(1));
         checkVal({tag, "Addr"},    32'(sramAddr[i]), 32'(0));
         checkVal({tag, "RspVld"},  32'(rspValid[i]), 32'(0));
         checkVal({tag, "Rdata"},   32'(rspRdata[i]), 32'(0));
         checkVal({tag, "Ready"},   32'(reqReady[i]), 32'(expReady));
         checkVal({tag, "InitDn"},  32'(initDone[i]), 32'(expReady));
         probeEn[i] = 1'b1;
         #1;
         checkVal({tag, "BusRel"},  32'(busVal(i)),   32'(PROBE));
         probeEn[i] = 1'b0;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, prevAcc, rel, nonZero;
      int unsigned w;
      logic expReady;
      reqValid = '0; reqWrite = '0; reqAddr = '0; reqWdata = '0; probeEn = '0;
      for (int i = 0; i < 2; i++) begin
         lastRead[i] = '0;
         lowRunOe[i] = 0;
         lowRunWe[i] = 0;
         for (int a = 0; a < int'(DEPTH); a++) begin
`ifdef SRAM_CTRL_INIT_CLEAR_EN
            mem[i][a]    = 16'hFFFF;
            shadow[i][a] = 16'h0000;
`else
            mem[i][a]    = 16'(a * 7 + i * 3 + 16'h0100);
            shadow[i][a] = mem[i][a];
`endif
         end
      end
`ifndef SRAM_CTRL_INIT_CLEAR_EN
      mem[1][11'h7FF] = 16'h1234; shadow[1][11'h7FF] = 16'h1234;
      mem[0][11'h010] = 16'h0F0F; shadow[0][11'h010] = 16'h0F0F;
      expReady = 1'b1;
`else
      expReady = 1'b0;
`endif

      #12;
      checkResetState("rst", expReady);
      @(negedge clock);
      reset = 1'b1;
      monEn = 1'b1;

`ifdef SRAM_CTRL_INIT_CLEAR_EN
      rel = cyc;
      for (int i = 0; i < 2; i++) begin
         w = (i == 0) ? W0 : W1;
         while (!initDone[i] && (cyc - rel) < int'(DEPTH * (w + 3)) + 50) begin
            checkVal("readyBeforeInit", 32'(reqReady[i]), 32'(0));
            @(negedge clock);
         end
         checkVal("initLatency", 32'(cyc - rel), 32'(DEPTH * (w + 3)));
         checkVal("readyAtInit", 32'(reqReady[i]), 32'(1));
      end
      for (int i = 0; i < 2; i++) begin
         nonZero = 0;
         for (int a = 0; a < int'(DEPTH); a++) if (mem[i][a] != '0) nonZero++;
         checkVal("memCleared", 32'(nonZero), 32'(0));
         doReq(i, 1'b0, 11'h000, '0, acc);
         doReq(i, 1'b0, 11'h400, '0, acc);
         doReq(i, 1'b0, 11'h7FF, '0, acc);
      end
`endif

      // Write then read back on the W=1 instance; read preloaded top word on W=4.
      doReq(0, 1'b1, 11'h005, 16'hBEEF, acc);
      repeat (4) @(negedge clock);
      doReq(0, 1'b0, 11'h005, '0, acc);
      doReq(1, 1'b0, 11'h7FF, '0, acc);
      repeat (8) @(negedge clock);

      // Requests held back to back: accepts must be exactly W+3 apart.
      for (int i = 0; i < 2; i++) begin
         w = (i == 0) ? W0 : W1;
         prevAcc = 0;
         for (int k = 0; k < 6; k++) begin
            doReq(i, (k % 2) == 0, AW'((k >> 1) & 1), 16'(16'h1000 + k * 16'h0111 + i), acc);
            if (k > 0) checkVal("acceptSpacing", 32'(acc - prevAcc), 32'(w + 3));
            prevAcc = acc;
         end
      end
      repeat (10) @(negedge clock);

      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < 10; k++) begin
            doReq(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), 16'($urandom), acc);
            repeat ($urandom_range(0, 3)) @(negedge clock);
         end
      end
      repeat (10) @(negedge clock);

`ifndef SRAM_CTRL_INIT_CLEAR_EN
      // Reset during the strobe of a write: the write must be dropped.
      doReq(0, 1'b1, 11'h010, 16'h5A3C, acc);
      @(negedge clock);
      checkVal("weLowInStrobe", 32'(weBar[0]), 32'(0));
      #2;
      reset = 1'b0;
      #1;
      void'(q0.pop_back());
      shadow[0][11'h010] = 16'h0F0F;
      lastRead[0] = '0;
      lastRead[1] = '0;
      checkResetState("midRst", 1'b1);
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      checkVal("memUnchanged", 32'(mem[0][11'h010]), 32'(16'h0F0F));
      doReq(0, 1'b0, 11'h010, '0, acc);
      repeat (8) @(negedge clock);
`endif

      checkVal("sbDrained0", 32'(q0.size()), 32'(0));
      checkVal("sbDrained1", 32'(q1.size()), 32'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Initiator-side controller for the 2048×16 asynchronous SRAM in the memory path. It turns single-word read/write requests into correctly sequenced address, data-bus and active-low strobe activity on the SRAM pins, then returns read data and a completion pulse. It sits between the datapath (MAR/MDR side) and the SRAM model, replacing hand-driven bench stimulus with synthesizable sequencing.

## Interface
- ADDR_W, 11, SRAM address width (depth 2^ADDR_W = 2048)
- DATA_W, 16, SRAM word width
- WAIT_CYCLES, 1, cycles a strobe is held low; legal range 1..15, 0 is a compile-time error

- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion pulse (reads and writes)
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid on reads
- init_done  out  1  memory initialisation finished
- sram_addr  out  ADDR_W  SRAM address
- sram_data  inout  DATA_W  SRAM bidirectional data bus
- sram_weBar  out  1  write enable, active-low
- sram_oeBar  out  1  output enable, active-low

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, plus CLEAR when the macro is enabled.
- IDLE: req_ready=1. A request is accepted on the edge where req_valid && req_ready; addr, wdata and write are latched; next state is SETUP.
- SETUP (1 cycle): sram_addr = latched addr; for writes, drive sram_data; both strobes high.
- STROBE (WAIT_CYCLES cycles): sram_weBar=0 on writes, sram_oeBar=0 on reads. Reads capture sram_data into rsp_rdata on the final STROBE edge.
- HOLD (1 cycle): strobes high; addr and write data are still driven; rsp_valid=1. Next state is IDLE.
- Invariants:
  - sram_weBar and sram_oeBar are never low together.
  - sram_data is driven only from SETUP through HOLD of a write, and never while sram_oeBar=0.
  - Strobes are glitch-free: they are register outputs.
- rsp_rdata holds its last read value across writes and idle periods.
- Requests held while req_ready=0 are ignored. The requester keeps them stable until accepted.
- Reset values:
  - sram_weBar=1, sram_oeBar=1.
  - sram_addr=0, sram_data released (Z).
  - rsp_valid=0, rsp_rdata=0.
  - req_ready=1 and init_done=1 without the macro; req_ready=0 and init_done=0 with it.
- Reset asserted mid-operation: strobes go high and the bus releases immediately (asynchronously). The in-flight request is dropped with no rsp_valid.

## Timing
- Accept edge = cycle 0. SETUP occupies cycle 1, STROBE occupies cycles 2..1+W, HOLD (rsp_valid) occupies cycle 2+W. req_ready is high again in cycle 3+W.
- Throughput: one access per WAIT_CYCLES+3 cycles. No back-to-back overlap.
- Address is stable one full cycle before and after every strobe-low interval.

## Configuration
- SRAM_CTRL_INIT_CLEAR_EN
  - Defined: after reset release, the CLEAR state writes 0 to addresses 0..2047 in ascending order, using the SETUP/STROBE/HOLD timing for each word. No rsp_valid is produced and req_ready=0 throughout. init_done rises the cycle after the last HOLD, and req_ready rises with it. Total duration is 2048×(W+3) cycles.
  - Undefined: no CLEAR state exists; init_done is tied 1.

## Structure
- Package sram_ctrl_pkg holds:
  - the state enum (IDLE/SETUP/STROBE/HOLD/CLEAR)
  - the ADDR_W/DATA_W defaults
  - DEPTH=2048
  - the WAIT_CYCLES maximum
- Sub-module sram_ctrl_timer is a loadable down-counter for the STROBE length. It has a load input, a done output, and width sized to the WAIT_CYCLES maximum.

## Test plan
- Write 0xBEEF to addr 0x005, then read 0x005: rsp_valid at cycles 3 and 3 after each accept (W=1), and rsp_rdata=0xBEEF.
- W=4, read addr 0x7FF preloaded with 0x1234: sram_oeBar low for exactly 4 cycles, rsp_valid in cycle 6, and rsp_rdata=0x1234.
- Hold req_valid continuously with alternating write/read on addr 0x000/0x001: each accept is spaced W+3 cycles apart; the weBar/oeBar overlap assertion and the bus-drive-while-oeBar-low assertion never fire.
- Assert reset in the STROBE cycle of a write to 0x010: strobes high and bus Z in the same cycle, no rsp_valid, and the SRAM word at 0x010 is unchanged.
- With SRAM_CTRL_INIT_CLEAR_EN and the SRAM pre-filled with 0xFFFF: req_ready=0 until init_done. init_done rises after 2048×4 cycles (W=1), and reads of 0x000, 0x400 and 0x7FF all return 0x0000.
